fuzz_out_misr: RTL

FUZZ_OUT_MISR -- requirements
Module: fuzz_out_misr

---
 rtl/fuzz_misr_pkg.sv | 20 ++
 rtl/fuzz_xor_fold.sv | 24 ++
 rtl/fuzz_out_misr.sv | 106 ++++++++++
 3 files changed

// File: rtl/fuzz_misr_pkg.sv
// Shared constants, FSM state type and the MISR step function for the
// fuzz output compactor.
package fuzz_misr_pkg;

  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_e;

  // One Galois-style shift with feedback, then absorb the folded sample.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] folded);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ folded;
  endfunction

endpackage

// File: rtl/fuzz_xor_fold.sv
// Purely combinational width fold: XOR of OUT_W-bit chunks of in_data,
// LSB-aligned, with the top chunk zero-padded.
module fuzz_xor_fold #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data
);

  localparam int NCHUNK = (IN_W + OUT_W - 1) / OUT_W;

  logic [NCHUNK*OUT_W-1:0] padded;

  always_comb begin
    padded = '0;
    padded[IN_W-1:0] = in_data;
    out_data = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      out_data = out_data ^ padded[i*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/fuzz_out_misr.sv
// Compacts a stream of flattened DUT output samples into a 32-bit MISR signature.
// Optional macro FUZZ_MISR_STALL_CNT_EN adds a saturating stall_count output.
module fuzz_out_misr
  import fuzz_misr_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             out_valid,
  input  logic [OUT_W-1:0] out_flat,
  output logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
`ifdef FUZZ_MISR_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic [CNT_W-1:0] sample_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  misr_state_e      state_q, state_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      folded;
  logic             start_ok;
  logic             accept;

  fuzz_xor_fold #(
    .IN_W  (OUT_W),
    .OUT_W (32)
  ) u_fold (
    .in_data  (out_flat),
    .out_data (folded)
  );

  assign start_ok = start && (state_q != ST_RUN);
  assign accept   = out_valid && (state_q == ST_RUN);
  assign cnt_inc  = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (start_ok) begin
      sig_d    = MISR_SEED;
      cnt_d    = '0;
      target_d = num_samples;
      state_d  = (num_samples == '0) ? ST_DONE : ST_RUN;
    end else if (accept) begin
      sig_d = misr_next(sig_q, folded);
      cnt_d = cnt_inc;
      // The run ends on the sample that reaches the target, so no wrap.
      if (cnt_inc == target_q) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sig_q    <= MISR_SEED;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

`ifdef FUZZ_MISR_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if ((state_q == ST_RUN) && !out_valid && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

  assign out_ready    = (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign signature    = sig_q;
  assign sample_count = cnt_q;

endmodule
